// File: rtl/arith_dec_pkg.sv
// Shared definitions for the arithmetic-decoder renormalization stage.
package arith_dec_pkg;

   localparam int unsigned RANGE_W     = 9;
   localparam int unsigned VALUE_W_DEF = 16;
   localparam int unsigned SHIFT_W     = 3;
   localparam int unsigned BN_W        = 4;
   localparam int unsigned BYTE_W      = 8;

   localparam logic signed [BN_W-1:0]   BN_INIT       = -4'sd8;
   localparam logic [SHIFT_W-1:0]       SHIFT_ILLEGAL = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT0,
      ST_INIT1,
      ST_READY,
      ST_FETCH,
      ST_RESP
   } state_e;

endpackage

// File: rtl/arith_renorm_refill.sv
// Range/value renormalization with at most one bitstream byte refill per request.
module arith_renorm_refill
   import arith_dec_pkg::*;
#(
   parameter int unsigned RANGE_INIT = 510,
   parameter int unsigned VALUE_W    = VALUE_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               init,
   input  logic               byte_valid,
   output logic               byte_ready,
   input  logic [BYTE_W-1:0]  byte_data,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [RANGE_W-1:0] req_range,
   input  logic [VALUE_W-1:0] req_value,
   input  logic [SHIFT_W-1:0] req_shift,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [RANGE_W-1:0] rsp_range,
   output logic [VALUE_W-1:0] rsp_value,
   output logic               err
);

   state_e                 state_q, state_d;
   logic [RANGE_W-1:0]     range_q, range_d;
   logic [VALUE_W-1:0]     value_q, value_d;
   logic signed [BN_W-1:0] bn_q, bn_d;
   logic signed [BN_W-1:0] bn_acc;
   logic                   err_q, err_d;
   logic                   byte_ready_q, byte_ready_d;
   logic                   req_ready_q, req_ready_d;
   logic                   rsp_valid_q, rsp_valid_d;

   // Next-state, datapath and registered handshake flags
   always_comb begin
      state_d  = state_q;
      range_d  = range_q;
      value_d  = value_q;
      bn_d     = bn_q;
      err_d    = err_q;
      bn_acc   = bn_q + BN_W'(req_shift);

      unique case (state_q)
         ST_IDLE: ;
         ST_INIT0: begin
            if (byte_valid) begin
               value_d = VALUE_W'(byte_data);
               state_d = ST_INIT1;
            end
         end
         ST_INIT1: begin
            if (byte_valid) begin
               value_d = {value_q[VALUE_W-BYTE_W-1:0], byte_data};
               range_d = RANGE_W'(RANGE_INIT);
               bn_d    = BN_INIT;
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            if (req_valid) begin
               if (req_shift == SHIFT_ILLEGAL) begin
                  err_d = 1'b1;
               end else begin
                  range_d = req_range << req_shift;
                  value_d = req_value << req_shift;
                  bn_d    = bn_acc;
                  // A non-negative counter means the shifted-in bits must come from a new byte
                  state_d = bn_acc[BN_W-1] ? ST_RESP : ST_FETCH;
               end
            end
         end
         ST_FETCH: begin
            if (byte_valid) begin
               value_d = value_q + (VALUE_W'(byte_data) << bn_q[2:0]);
               bn_d    = bn_q + BN_INIT;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_READY;
         end
         default: state_d = ST_IDLE;
      endcase

      // Init restarts the slice from any state
      if (init) begin
         state_d = ST_INIT0;
         range_d = RANGE_W'(RANGE_INIT);
         bn_d    = BN_INIT;
      end

      byte_ready_d = (state_d == ST_INIT0) || (state_d == ST_INIT1) || (state_d == ST_FETCH);
      req_ready_d  = (state_d == ST_READY);
      rsp_valid_d  = (state_d == ST_RESP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         range_q      <= RANGE_W'(RANGE_INIT);
         value_q      <= '0;
         bn_q         <= BN_INIT;
         err_q        <= 1'b0;
         byte_ready_q <= 1'b0;
         req_ready_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         range_q      <= range_d;
         value_q      <= value_d;
         bn_q         <= bn_d;
         err_q        <= err_d;
         byte_ready_q <= byte_ready_d;
         req_ready_q  <= req_ready_d;
         rsp_valid_q  <= rsp_valid_d;
      end
   end

   assign byte_ready = byte_ready_q;
   assign req_ready  = req_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_range  = range_q;
   assign rsp_value  = value_q;
   assign err        = err_q;

endmodule

// File: tb/tb_arith_renorm_refill.sv
// Randomized self-checking bench for arith_renorm_refill against an arithmetic reference model.
module tb_arith_renorm_refill;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        init = 1'b0;
   logic        byte_valid = 1'b0;
   logic        byte_ready;
   logic [7:0]  byte_data = 8'h00;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [8:0]  req_range = 9'h0;
   logic [15:0] req_value = 16'h0;
   logic [2:0]  req_shift = 3'h0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [8:0]  rsp_range;
   logic [15:0] rsp_value;
   logic        err;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_range = 510;
   int m_value = 0;
   int m_bn    = -8;
   bit m_err   = 1'b0;

   arith_renorm_refill #(.RANGE_INIT(510), .VALUE_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .init(init),
      .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_range(req_range), .req_value(req_value), .req_shift(req_shift),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_range(rsp_range), .rsp_value(rsp_value), .err(err)
   );

   always #5 clk = ~clk;

   function automatic bit model_accept(input int r, input int v, input int s);
      m_range = (r * (1 << s)) % 512;
      m_value = (v * (1 << s)) % 65536;
      m_bn    = m_bn + s;
      return (m_bn >= 0);
   endfunction

   function automatic void model_byte(input int b);
      m_value = (m_value + b * (1 << m_bn)) % 65536;
      m_bn    = m_bn - 8;
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_init(input logic [7:0] b0, input logic [7:0] b1);
      init = 1'b1;
      cycle();
      init = 1'b0;
      byte_valid = 1'b1;
      byte_data  = b0;
      cycle();
      byte_data  = b1;
      cycle();
      byte_valid = 1'b0;
      m_value = int'(b0) * 256 + int'(b1);
      m_range = 510;
      m_bn    = -8;
   endtask

   task automatic issue_req(input logic [8:0] r, input logic [15:0] v, input logic [2:0] s,
                            output bit ok);
      int n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         cycle();
         n++;
      end
      ok = (req_ready === 1'b1);
      req_range = r;
      req_value = v;
      req_shift = s;
      req_valid = 1'b1;
      cycle();
      req_valid = 1'b0;
   endtask

   task automatic release_rsp();
      rsp_ready = 1'b1;
      cycle();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_byte_ready: got %b want 0", byte_ready); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
      checks++; if (rsp_range !== 9'd510) begin errors++; $display("FAIL reset_range: got %0d want 510", rsp_range); end
      checks++; if (rsp_value !== 16'h0) begin errors++; $display("FAIL reset_value: got %h want 0000", rsp_value); end
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();
      checks++; if ({req_ready, rsp_valid, byte_ready} !== 3'b000) begin errors++; $display("FAIL idle_flags: got %b want 000", {req_ready, rsp_valid, byte_ready}); end
   endtask

   task automatic test_init();
      do_init(8'hA5, 8'h3C);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL init_req_ready: got %b want 1", req_ready); end
      checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL init_byte_ready: got %b want 0", byte_ready); end
      checks++; if (rsp_range !== 9'd510) begin errors++; $display("FAIL init_range: got %0d want 510", rsp_range); end
      checks++; if (rsp_value !== 16'hA53C) begin errors++; $display("FAIL init_value: got %h want a53c", rsp_value); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL init_rsp_valid: got %b want 0", rsp_valid); end
   endtask

   task automatic test_no_fetch();
      bit ok;
      bit f;
      issue_req(9'd6, 16'h0200, 3'd6, ok);
      f = model_accept(6, 16'h0200, 6);
      checks++; if (!ok || f) begin errors++; $display("FAIL nofetch_accept: ready %b fetch %b want 1 0", ok, f); end
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL nofetch_latency: got %b want 1", rsp_valid); end
      checks++; if (rsp_range !== 9'd384) begin errors++; $display("FAIL nofetch_range: got %0d want 384", rsp_range); end
      checks++; if (rsp_value !== 16'h8000) begin errors++; $display("FAIL nofetch_value: got %h want 8000", rsp_value); end
      checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL nofetch_byte_ready: got %b want 0", byte_ready); end
      release_rsp();
      checks++; if ({req_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL nofetch_return: got %b want 10", {req_ready, rsp_valid}); end
   endtask

   task automatic test_fetch();
      bit ok;
      bit f;
      issue_req(9'd3, 16'h0001, 3'd1, ok);
      f = model_accept(3, 1, 1);
      checks++; if (!ok || f || rsp_valid !== 1'b1) begin errors++; $display("FAIL prefetch_step: ready %b fetch %b rsp_valid %b want 1 0 1", ok, f, rsp_valid); end
      release_rsp();
      issue_req(9'd100, 16'h1000, 3'd2, ok);
      f = model_accept(100, 16'h1000, 2);
      checks++; if (!ok || !f) begin errors++; $display("FAIL fetch_accept: ready %b fetch %b want 1 1", ok, f); end
      for (int i = 0; i < 3; i++) begin
         checks++; if ({byte_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL fetch_stall: got %b want 10", {byte_ready, rsp_valid}); end
         cycle();
      end
      byte_valid = 1'b1;
      byte_data  = 8'h81;
      cycle();
      byte_valid = 1'b0;
      model_byte(8'h81);
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL fetch_latency: got %b want 1", rsp_valid); end
      checks++; if (rsp_range !== 9'd400) begin errors++; $display("FAIL fetch_range: got %0d want 400", rsp_range); end
      checks++; if (rsp_value !== 16'h4102) begin errors++; $display("FAIL fetch_value: got %h want 4102", rsp_value); end
      checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL fetch_byte_drop: got %b want 0", byte_ready); end
      release_rsp();
   endtask

   task automatic test_backpressure();
      bit ok;
      bit f;
      logic [8:0]  r = 9'($urandom);
      logic [15:0] v = 16'($urandom);
      issue_req(r, v, 3'd3, ok);
      f = model_accept(int'(r), int'(v), 3);
      checks++; if (!ok || f) begin errors++; $display("FAIL bp_accept: ready %b fetch %b want 1 0", ok, f); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_range !== 9'(m_range) || rsp_value !== 16'(m_value)) begin
            errors++;
            $display("FAIL bp_hold: valid %b ready %b range %0d value %h want 1 0 %0d %h",
                     rsp_valid, req_ready, rsp_range, rsp_value, m_range, m_value);
         end
         cycle();
      end
      release_rsp();
   endtask

   task automatic test_illegal_shift();
      bit ok;
      bit f;
      issue_req(9'h1FF, 16'hFFFF, 3'd7, ok);
      m_err = 1'b1;
      checks++; if (!ok || err !== 1'b1) begin errors++; $display("FAIL illegal_err: ready %b err %b want 1 1", ok, err); end
      checks++; if ({rsp_valid, req_ready, byte_ready} !== 3'b010) begin errors++; $display("FAIL illegal_state: got %b want 010", {rsp_valid, req_ready, byte_ready}); end
      checks++; if (rsp_range !== 9'(m_range) || rsp_value !== 16'(m_value)) begin errors++; $display("FAIL illegal_hold: got %0d %h want %0d %h", rsp_range, rsp_value, m_range, m_value); end
      cycle();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %b want 1", err); end
      issue_req(9'd5, 16'h0123, 3'd2, ok);
      f = model_accept(5, 16'h0123, 2);
      checks++; if (!ok || f || rsp_valid !== 1'b1) begin errors++; $display("FAIL illegal_next: ready %b fetch %b valid %b want 1 0 1", ok, f, rsp_valid); end
      checks++; if (rsp_range !== 9'(m_range) || rsp_value !== 16'(m_value) || err !== 1'b1) begin errors++; $display("FAIL illegal_next_data: got %0d %h %b want %0d %h 1", rsp_range, rsp_value, err, m_range, m_value); end
      release_rsp();
   endtask

   task automatic test_random();
      bit ok;
      bit f;
      for (int t = 0; t < 40; t++) begin
         logic [8:0]  r = 9'($urandom);
         logic [15:0] v = 16'($urandom);
         logic [2:0]  s = 3'($urandom_range(0, 7));
         logic [7:0]  b = 8'($urandom);
         issue_req(r, v, s, ok);
         checks++; if (!ok) begin errors++; $display("FAIL rnd_req_timeout: txn %0d", t); end
         if (s == 3'd7) begin
            m_err = 1'b1;
            checks++; if (err !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd_illegal: err %b valid %b want 1 0", err, rsp_valid); end
            continue;
         end
         f = model_accept(int'(r), int'(v), int'(s));
         if (f) begin
            checks++; if ({byte_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL rnd_fetch_wait: txn %0d got %b want 10", t, {byte_ready, rsp_valid}); end
            repeat ($urandom_range(0, 3)) cycle();
            byte_valid = 1'b1;
            byte_data  = b;
            cycle();
            byte_valid = 1'b0;
            model_byte(int'(b));
         end
         checks++;
         if (rsp_valid !== 1'b1 || byte_ready !== 1'b0 || rsp_range !== 9'(m_range) || rsp_value !== 16'(m_value) || err !== m_err) begin
            errors++;
            $display("FAIL rnd_rsp: txn %0d valid %b byte_ready %b range %0d value %h err %b want 1 0 %0d %h %b",
                     t, rsp_valid, byte_ready, rsp_range, rsp_value, err, m_range, m_value, m_err);
         end
         repeat ($urandom_range(0, 2)) cycle();
         checks++; if (rsp_valid !== 1'b1 || rsp_value !== 16'(m_value)) begin errors++; $display("FAIL rnd_hold: txn %0d valid %b value %h want 1 %h", t, rsp_valid, rsp_value, m_value); end
         release_rsp();
      end
   endtask

   task automatic test_abort();
      bit ok;
      bit f;
      do_init(8'h12, 8'h34);
      issue_req(9'd7, 16'h0001, 3'd6, ok);
      f = model_accept(7, 1, 6);
      release_rsp();
      issue_req(9'd7, 16'h0001, 3'd2, ok);
      f = model_accept(7, 1, 2);
      checks++; if (!f || byte_ready !== 1'b1) begin errors++; $display("FAIL abort_fetch_setup: fetch %b byte_ready %b want 1 1", f, byte_ready); end
      rst_n = 1'b0;
      #1;
      checks++; if ({byte_ready, rsp_valid, req_ready, err} !== 4'b0000) begin errors++; $display("FAIL abort_reset_flags: got %b want 0000", {byte_ready, rsp_valid, req_ready, err}); end
      checks++; if (rsp_range !== 9'd510 || rsp_value !== 16'h0) begin errors++; $display("FAIL abort_reset_data: got %0d %h want 510 0000", rsp_range, rsp_value); end
      cycle();
      cycle();
      rst_n = 1'b1;
      m_err = 1'b0;
      cycle();
      cycle();
      checks++; if ({byte_ready, rsp_valid, req_ready} !== 3'b000) begin errors++; $display("FAIL abort_idle: got %b want 000", {byte_ready, rsp_valid, req_ready}); end
      do_init(8'h55, 8'hAA);
      issue_req(9'd3, 16'h0004, 3'd1, ok);
      f = model_accept(3, 4, 1);
      checks++; if (!ok || rsp_valid !== 1'b1) begin errors++; $display("FAIL abort_resp_setup: ready %b valid %b want 1 1", ok, rsp_valid); end
      init = 1'b1;
      cycle();
      init = 1'b0;
      checks++; if ({rsp_valid, byte_ready, req_ready} !== 3'b010) begin errors++; $display("FAIL abort_init_resp: got %b want 010", {rsp_valid, byte_ready, req_ready}); end
      byte_valid = 1'b1;
      byte_data  = 8'h01;
      cycle();
      byte_data  = 8'h02;
      cycle();
      byte_valid = 1'b0;
      checks++; if (req_ready !== 1'b1 || rsp_value !== 16'h0102 || rsp_range !== 9'd510) begin errors++; $display("FAIL abort_reinit: ready %b value %h range %0d want 1 0102 510", req_ready, rsp_value, rsp_range); end
   endtask

   initial begin
      test_reset();
      test_init();
      test_no_fetch();
      test_fetch();
      test_backpressure();
      test_illegal_shift();
      test_random();
      test_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/arith_renorm_refill.md
ARITH_RENORM_REFILL -- requirements
Module: arith_renorm_refill

Interface
REQ-001 SHALL have parameter RANGE_INIT, default 510, the range value loaded at init.
REQ-002 SHALL have parameter VALUE_W, default 16, the width of the arithmetic value.
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port init  in  1  pulse that starts a slice init (2-byte value load).
REQ-006 SHALL have ports byte_valid  in  1 / byte_ready  out  1 / byte_data  in  8  bitstream byte handshake.
REQ-007 SHALL have ports req_valid  in  1 / req_ready  out  1  renorm request handshake.
REQ-008 SHALL have ports req_range  in  9 / req_value  in  VALUE_W / req_shift  in  3  request payload: pre-renorm range, value and RenormTableROM shift count (0..6).
REQ-009 SHALL have ports rsp_valid  out  1 / rsp_ready  in  1 / rsp_range  out  9 / rsp_value  out  VALUE_W  renormalized result.
REQ-010 SHALL have port err  out  1  sticky illegal-shift flag.

Function
REQ-011 SHALL implement states IDLE, INIT0, INIT1, READY, FETCH, RESP.
REQ-012 SHALL go IDLE->INIT0 on init; INIT0 and INIT1 each accept one byte (byte_ready=1): value = {byte0, byte1}, bits_needed = -8, rsp_range = RANGE_INIT, then -> READY.
REQ-013 SHALL assert req_ready only in READY; a transfer occurs when req_valid && req_ready.
REQ-014 SHALL on accept compute range = req_range << req_shift (9 bits), value = req_value << req_shift (truncated to VALUE_W), bits_needed += req_shift.
REQ-015 SHALL, if the new bits_needed >= 0, enter FETCH, hold byte_ready=1, and on the byte transfer add byte_data << bits_needed to value and subtract 8 from bits_needed; else go directly to RESP.
REQ-016 SHALL hold bits_needed as a signed 4-bit counter in -8..-1 between requests; at most one byte is fetched per request.
REQ-017 SHALL present rsp_valid in RESP with stable payload until rsp_ready; then return to READY.
REQ-018 SHALL have latency of exactly 1 cycle from accept to rsp_valid when no fetch is needed, and 1 cycle after the byte transfer otherwise.
REQ-019 SHALL treat req_shift = 0 as pass-through (range and value unchanged, no fetch).
REQ-020 SHALL on req_shift = 7 set err, leave all state unchanged and remain in READY without a response.
REQ-021 SHALL accept init in any state, aborting any pending fetch/response and restarting at INIT0.
REQ-022 SHALL deassert byte_ready in all states other than INIT0, INIT1 and FETCH; stall indefinitely while byte_valid=0.

Reset
REQ-023 SHALL on rst_n=0 force state IDLE, value=0, range=RANGE_INIT, bits_needed=-8, err=0.
REQ-024 SHALL drive req_ready=0, rsp_valid=0 and byte_ready=0 during and after reset until the states named above.
REQ-025 SHALL discard any in-flight request or byte on reset, with no response produced.

Structure
REQ-026 SHALL take the state enum, RANGE_W=9, VALUE_W default and BN_INIT=-8 from the shared package arith_dec_pkg.
REQ-027 SHALL contain no sub-module; RenormTableROM stays in the upstream bin-decode stage that drives req_shift.

Verification
REQ-028 SHALL test init: init, then bytes 0xA5, 0x3C -> READY, rsp_range=510, value=0xA53C internally, bits_needed=-8.
REQ-029 SHALL test no-fetch: range 6, value 0x0200, shift 6 -> rsp_range=384, rsp_value=0x8000 one cycle after accept, bits_needed=-2, byte_ready never high.
REQ-030 SHALL test fetch: after bits_needed=-1, range 100, value 0x1000, shift 2, byte 0x81 after a 3-cycle stall -> rsp_range=400, rsp_value=0x4102, bits_needed=-7.
REQ-031 SHALL test backpressure: rsp_ready low 5 cycles -> rsp payload stable, req_ready=0 throughout.
REQ-032 SHALL test an illegal shift: req_shift=7 -> err=1 sticky, no rsp_valid, state unchanged; next legal request completes normally.
REQ-033 SHALL test aborts: rst_n low during FETCH -> IDLE, no response; init during RESP -> INIT0, rsp_valid drops.
